// File: rtl/pipe_scroller.sv
// Pipe position generator: scrolls three pipes left each frame, respawns them at the
// right with an LFSR-chosen gap height, and runs the idle/run/frozen game phase.
module pipe_scroller #(
  parameter int unsigned SPEED     = 2,
  parameter int unsigned SPACING   = 256,
  parameter int unsigned PIPE_W    = 72,
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned BY_MIN    = 250,
  parameter int unsigned BIRD_X    = 100,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        crash,
  input  logic        restart,
  output logic [10:0] bx,
  output logic [10:0] bx2,
  output logic [10:0] bx3,
  output logic [10:0] by,
  output logic [10:0] by2,
  output logic [10:0] by3,
  output logic        score_pulse,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FROZEN = 2'b10
  } state_t;

  localparam logic [10:0] SPEED_W     = 11'(SPEED);
  localparam logic [10:0] BIRD_W      = 11'(BIRD_X);
  localparam logic [10:0] BY_BASE     = 11'(BY_MIN);
  localparam logic [10:0] RESPAWN_ADD = 11'(3 * SPACING - SPEED);
  localparam logic [10:0] BX_R0       = 11'(SCREEN_W + PIPE_W - 1);
  localparam logic [10:0] BX_R1       = 11'(SCREEN_W + PIPE_W - 1 + SPACING);
  localparam logic [10:0] BX_R2       = 11'(SCREEN_W + PIPE_W - 1 + 2 * SPACING);
  localparam logic [2:0][10:0] BX_RST = {BX_R2, BX_R1, BX_R0};
  localparam logic [2:0][10:0] BY_RST = {11'(BY_MIN + 96), 11'(BY_MIN + 64), 11'(BY_MIN + 32)};

  state_t           state_q, state_d;
  logic [2:0][10:0] bx_q, bx_d;
  logic [2:0][10:0] by_q, by_d;
  logic             score_q, score_d;
  logic [15:0]      lfsr_q, lfsr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bx_q    <= BX_RST;
      by_q    <= BY_RST;
      score_q <= 1'b0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      score_q <= score_d;
      lfsr_q  <= lfsr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    score_d = 1'b0;
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    if (restart) begin
      state_d = ST_IDLE;
      bx_d    = BX_RST;
      by_d    = BY_RST;
    end else begin
      case (state_q)
        ST_IDLE:   if (start) state_d = ST_RUN;
        ST_RUN: begin
          if (crash) begin
            state_d = ST_FROZEN;
          end else if (frame_tick) begin
            // All respawning pipes share this cycle's LFSR sample; respawn never scores.
            for (int unsigned i = 0; i < 3; i++) begin
              if (bx_q[i] > SPEED_W) begin
                bx_d[i] = bx_q[i] - SPEED_W;
                if (bx_q[i] >= BIRD_W && bx_d[i] < BIRD_W) score_d = 1'b1;
              end else begin
                bx_d[i] = bx_q[i] + RESPAWN_ADD;
                by_d[i] = BY_BASE + {4'b0000, lfsr_q[6:0]};
              end
            end
          end
        end
        ST_FROZEN: ;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  assign bx          = bx_q[0];
  assign bx2         = bx_q[1];
  assign bx3         = bx_q[2];
  assign by          = by_q[0];
  assign by2         = by_q[1];
  assign by3         = by_q[2];
  assign score_pulse = score_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Self-checking bench for pipe_scroller: directed game scenarios plus random control
// traffic, all compared every cycle against an integer reference model.
module tb_pipe_scroller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0, start = 1'b0, crash = 1'b0, restart = 1'b0;
  logic [10:0] bx, bx2, bx3, by, by2, by3;
  logic        score_pulse;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  pipe_scroller #(
    .SPEED(2), .SPACING(256), .PIPE_W(72), .SCREEN_W(640),
    .BY_MIN(250), .BIRD_X(100), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .crash(crash),
    .restart(restart), .bx(bx), .bx2(bx2), .bx3(bx3), .by(by), .by2(by2), .by3(by3),
    .score_pulse(score_pulse), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 run, 2 frozen; positions as plain integers.
  int          m_bx[3], m_by[3];
  int          m_phase, m_pulse;
  int unsigned m_lfsr;
  logic [68:0] act;
  assign act = {bx, bx2, bx3, by, by2, by3, state, score_pulse};

  function automatic logic [68:0] exp_vec();
    return {11'(m_bx[0]), 11'(m_bx[1]), 11'(m_bx[2]),
            11'(m_by[0]), 11'(m_by[1]), 11'(m_by[2]), 2'(m_phase), 1'(m_pulse)};
  endfunction

  task automatic model_reset(input bit full);
    for (int i = 0; i < 3; i++) begin
      m_bx[i] = 711 + 256 * i;
      m_by[i] = 282 + 32 * i;
    end
    m_phase = 0;
    m_pulse = 0;
    if (full) m_lfsr = 'hACE1;
  endtask

  task automatic model_step(input bit t, input bit s, input bit c, input bit r);
    int unsigned sample;
    sample  = m_lfsr;
    m_lfsr  = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
    m_pulse = 0;
    if (r) begin
      model_reset(1'b0);
    end else if (m_phase == 0) begin
      if (s) m_phase = 1;
    end else if (m_phase == 1) begin
      if (c) m_phase = 2;
      else if (t) begin
        for (int i = 0; i < 3; i++) begin
          if (m_bx[i] > 2) begin
            if (m_bx[i] >= 100 && m_bx[i] - 2 < 100) m_pulse = 1;
            m_bx[i] -= 2;
          end else begin
            m_bx[i] += 3 * 256 - 2;
            m_by[i] = 250 + int'(sample % 128);
          end
        end
      end
    end
  endtask

  // Drive one clock cycle of inputs from a negedge; returns at the following negedge.
  task automatic cycle(input bit t, input bit s, input bit c, input bit r);
    frame_tick = t; start = s; crash = c; restart = r;
    @(posedge clk);
    model_step(t, s, c, r);
    @(negedge clk);
    frame_tick = 0; start = 0; crash = 0; restart = 0;
  endtask

  task automatic run_frames(input int n, input string tag);
    for (int f = 0; f < n; f++) begin
      for (int k = 0; k < 2; k++) begin
        cycle(k == 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (act !== exp_vec()) begin
          errors++;
          $display("FAIL %s frame %0d: got bx=%0d,%0d,%0d by=%0d,%0d,%0d st=%0d sp=%0b want %h (vec got %h)",
                   tag, f, bx, bx2, bx3, by, by2, by3, state, score_pulse, exp_vec(), act);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset(1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if ({bx, bx2, bx3, by, by2, by3, state, score_pulse} !==
        {11'd711, 11'd967, 11'd1223, 11'd282, 11'd314, 11'd346, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got bx=%0d,%0d,%0d by=%0d,%0d,%0d st=%0d sp=%0b want 711,967,1223 282,314,346 0 0",
               bx, bx2, bx3, by, by2, by3, state, score_pulse);
    end
    rst = 1'b0;
    run_frames(20, "idle_hold");
    checks++;
    if (bx !== 11'd711 || bx3 !== 11'd1223 || state !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_move: got bx=%0d bx3=%0d st=%0d want 711 1223 0", bx, bx3, state);
    end
  endtask

  task automatic test_run();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_frames(10, "run10");
    checks++;
    if ({state, bx, bx2, bx3, by, by2, by3} !==
        {2'b01, 11'd691, 11'd947, 11'd1203, 11'd282, 11'd314, 11'd346}) begin
      errors++;
      $display("FAIL run_10_ticks: got st=%0d bx=%0d,%0d,%0d by=%0d,%0d,%0d want 1 691,947,1203 282,314,346",
               state, bx, bx2, bx3, by, by2, by3);
    end
  endtask

  task automatic test_score();
    run_frames(295, "to305");
    checks++;
    if (bx !== 11'd101 || score_pulse !== 1'b0) begin
      errors++;
      $display("FAIL tick305: got bx=%0d sp=%0b want 101 0", bx, score_pulse);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bx !== 11'd99 || score_pulse !== 1'b1) begin
      errors++;
      $display("FAIL tick306_score: got bx=%0d sp=%0b want 99 1", bx, score_pulse);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (score_pulse !== 1'b0) begin
      errors++;
      $display("FAIL score_one_cycle: got sp=%0b want 0", score_pulse);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bx !== 11'd97 || score_pulse !== 1'b0) begin
      errors++;
      $display("FAIL tick307: got bx=%0d sp=%0b want 97 0", bx, score_pulse);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_respawn();
    int unsigned samp;
    int          ob2, ob3;
    run_frames(48, "to355");
    checks++;
    if (bx !== 11'd1) begin
      errors++;
      $display("FAIL tick355: got bx=%0d want 1", bx);
    end
    samp = m_lfsr;
    ob2  = m_bx[1];
    ob3  = m_bx[2];
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bx !== 11'd767 || by !== 11'(250 + samp % 128) || bx2 !== 11'(ob2 - 2) ||
        bx3 !== 11'(ob3 - 2) || score_pulse !== 1'b0) begin
      errors++;
      $display("FAIL respawn: got bx=%0d by=%0d bx2=%0d bx3=%0d sp=%0b want 767 %0d %0d %0d 0",
               bx, by, bx2, bx3, score_pulse, 250 + samp % 128, ob2 - 2, ob3 - 2);
    end
    run_frames(5, "post_respawn");
  endtask

  task automatic test_crash_restart();
    int sb[3];
    for (int i = 0; i < 3; i++) sb[i] = m_bx[i];
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (state !== 2'b10 || bx !== 11'(sb[0]) || bx2 !== 11'(sb[1]) || bx3 !== 11'(sb[2]) ||
        score_pulse !== 1'b0) begin
      errors++;
      $display("FAIL crash_freeze: got st=%0d bx=%0d,%0d,%0d sp=%0b want 2 %0d,%0d,%0d 0",
               state, bx, bx2, bx3, score_pulse, sb[0], sb[1], sb[2]);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_frames(5, "frozen_hold");
    checks++;
    if (state !== 2'b10 || bx !== 11'(sb[0])) begin
      errors++;
      $display("FAIL frozen_hold_end: got st=%0d bx=%0d want 2 %0d", state, bx, sb[0]);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({state, bx, bx2, bx3, by, by2, by3} !==
        {2'b00, 11'd711, 11'd967, 11'd1223, 11'd282, 11'd314, 11'd346}) begin
      errors++;
      $display("FAIL restart_reload: got st=%0d bx=%0d,%0d,%0d by=%0d,%0d,%0d want 0 711,967,1223 282,314,346",
               state, bx, bx2, bx3, by, by2, by3);
    end
    // Second full lap: the respawn height exposes whether the LFSR kept running.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_frames(360, "second_lap");
  endtask

  task automatic test_async_reset();
    run_frames(20, "pre_async");
    #2 rst = 1'b1;
    model_reset(1'b1);
    #1;
    checks++;
    if ({bx, bx2, bx3, by, by2, by3, state, score_pulse} !==
        {11'd711, 11'd967, 11'd1223, 11'd282, 11'd314, 11'd346, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got bx=%0d,%0d,%0d by=%0d,%0d,%0d st=%0d sp=%0b want 711,967,1223 282,314,346 0 0",
               bx, bx2, bx3, by, by2, by3, state, score_pulse);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_frames(4, "post_async");
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_frames(10, "post_async_run");
  endtask

  task automatic test_random();
    bit t, s, c, r;
    for (int n = 0; n < 4000; n++) begin
      t = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 299) == 0);
      r = ($urandom_range(0, 599) == 0);
      cycle(t, s, c, r);
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got bx=%0d,%0d,%0d by=%0d,%0d,%0d st=%0d sp=%0b want %h (vec got %h)",
                 n, bx, bx2, bx3, by, by2, by3, state, score_pulse, exp_vec(), act);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_run();
    test_score();
    test_respawn();
    test_crash_restart();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
